regfile_wb_arbiter: RTL and testbench

- Write-back initiator for the register file write port: drives writeReg/writeData/writeEnable.
- Merges two result sources: single-cycle ALU results, and multi-cycle MDU (multiply/divide) results buffered in a small FIFO.
- Provides a per-register pending mask so decode can stall on outstanding MDU writes.
- Sits between the EX/MDU stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back initiator for the register file write port.
// Merges single-cycle ALU results with multi-cycle MDU results queued in a
// small FIFO, and exports a per-register pending mask for decode stalls.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   alu_valid/alu_ready           ALU result handshake (ready is combinational)
//   alu_reg, alu_data             ALU destination register and result
//   mdu_valid/mdu_ready           MDU result handshake (ready = !full)
//   mdu_reg, mdu_data             MDU destination register and result
//   writeReg/writeData/writeEnable registered register file write port
//   pending                       bit r set while a queued MDU entry targets r
//   fifo_count                    current MDU FIFO occupancy
//
// Optional feature macro: WB_BYPASS_EN. When defined, an MDU result arriving
// with the FIFO empty and no ALU transfer skips the FIFO and is written in
// the next cycle.

module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_reg,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [ADDR_W-1:0]        mdu_reg,
    input  logic [DATA_W-1:0]        mdu_data,
    output logic [ADDR_W-1:0]        writeReg,
    output logic [DATA_W-1:0]        writeData,
    output logic                     writeEnable,
    output logic [2**ADDR_W-1:0]     pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
    logic [ADDR_W-1:0] ent_reg_d  [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [DEPTH-1:0]  ent_vld_q, ent_vld_d;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ST_W-1:0]   starve_q, starve_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic fifo_empty;
    logic fifo_full;
    logic starved;
    logic alu_xfer;
    logic alu_wr;
    logic mdu_nz;
    logic mdu_byp;
    logic push;
    logic pop;

    // Pending mask is rebuilt from the valid entries every cycle, so a bit
    // drops as soon as the last entry for that register has popped.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i]) begin
                pending[ent_reg_q[i]] = 1'b1;
            end
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign starved    = (starve_q == ST_W'(STARVE_MAX)) && !fifo_empty;

    // ALU is held off on a WAW hazard with a queued MDU write, or when it
    // has starved the FIFO for too long.
    assign alu_ready = !((pending[alu_reg] && (alu_reg != '0)) || starved);
    assign mdu_ready = !fifo_full;

    assign alu_xfer = alu_valid && alu_ready;
    assign alu_wr   = alu_xfer && (alu_reg != '0);
    assign mdu_nz   = mdu_valid && mdu_ready && (mdu_reg != '0);

`ifdef WB_BYPASS_EN
    assign mdu_byp = mdu_nz && fifo_empty && !alu_xfer;
`else
    assign mdu_byp = 1'b0;
`endif

    assign push = mdu_nz && !mdu_byp;
    assign pop  = !alu_wr && !fifo_empty;

    always_comb begin
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        ent_vld_d  = ent_vld_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        we_d       = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;

        // Pop before push: they can only share a slot when full, and a push
        // is impossible then.
        if (pop) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = rd_ptr_q + 1'b1;
        end
        if (push) begin
            ent_vld_d[wr_ptr_q]  = 1'b1;
            ent_reg_d[wr_ptr_q]  = mdu_reg;
            ent_data_d[wr_ptr_q] = mdu_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (alu_wr) begin
            we_d    = 1'b1;
            wreg_d  = alu_reg;
            wdata_d = alu_data;
        end else if (pop) begin
            we_d    = 1'b1;
            wreg_d  = ent_reg_q[rd_ptr_q];
            wdata_d = ent_data_q[rd_ptr_q];
        end else if (mdu_byp) begin
            we_d    = 1'b1;
            wreg_d  = mdu_reg;
            wdata_d = mdu_data;
        end

        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_wr && (starve_q != ST_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            ent_vld_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
        end else begin
            ent_reg_q  <= ent_reg_d;
            ent_data_q <= ent_data_d;
            ent_vld_q  <= ent_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            we_q       <= we_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign writeEnable = we_q;
    assign writeReg    = wreg_q;
    assign writeData   = wdata_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write-back scoreboard.
// Expected register file writes are queued at issue and checked in order.

module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_reg     (mdu_reg),
        .mdu_data    (mdu_data),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .pending     (pending),
        .fifo_count  (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total;
    int  bad;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_send(input logic [4:0] r, input logic [31:0] d);
        int n;
        n = 0;
        alu_valid = 1'b1;
        alu_reg   = r;
        alu_data  = d;
        @(negedge clk);
        while (!alu_ready && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("alu_hs", 64'(alu_ready), 64'd1);
        if (r != 5'd0) expect_wr(r, d);
        tick();
        alu_valid = 1'b0;
    endtask

    task automatic mdu_send(input logic [4:0] r, input logic [31:0] d);
        int n;
        n = 0;
        mdu_valid = 1'b1;
        mdu_reg   = r;
        mdu_data  = d;
        @(negedge clk);
        while (!mdu_ready && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("mdu_hs", 64'(mdu_ready), 64'd1);
        if (r != 5'd0) expect_wr(r, d);
        tick();
        mdu_valid = 1'b0;
    endtask

    // Per-cycle expectations for the full-FIFO scenario.
    logic ar [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1};
    logic mr [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    int   cn [10] = '{0, 1, 2, 3, 4, 3, 3, 3, 3, 2};

    initial begin
        int ai;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        mdu_valid = 1'b0;
        mdu_reg   = '0;
        mdu_data  = '0;

        fork
            forever begin
                wr_t w;
                @(negedge clk);
                if (rst_n && writeEnable) begin
                    if (exp_q.size() == 0) begin
                        chk("wb_unexpected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        w = exp_q.pop_front();
                        chk("wb_reg", 64'(writeReg), 64'(w.r));
                        chk("wb_data", 64'(writeData), 64'(w.d));
                    end
                end
            end
        join_none

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we", 64'(writeEnable), 64'd0);
        chk("rst_reg", 64'(writeReg), 64'd0);
        chk("rst_data", 64'(writeData), 64'd0);
        chk("rst_cnt", 64'(fifo_count), 64'd0);
        chk("rst_pend", 64'(pending), 64'd0);
        chk("rst_mdu_rdy", 64'(mdu_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("idle_we", 64'(writeEnable), 64'd0);
        tick();

        // ALU only
        alu_send(5'd5, 32'h0000_00AA);
        @(negedge clk);
        chk("alu_lat_we", 64'(writeEnable), 64'd1);
        chk("alu_lat_reg", 64'(writeReg), 64'd5);
        tick();
        @(negedge clk);
        chk("alu_after_we", 64'(writeEnable), 64'd0);
        tick();

        // MDU only
        mdu_send(5'd7, 32'h1234_5678);
        @(negedge clk);
        chk("mdu_pend_set", 64'(pending[7]), 64'd1);
        chk("mdu_cnt1", 64'(fifo_count), 64'd1);
        chk("mdu_we_n1", 64'(writeEnable), 64'd0);
        tick();
        @(negedge clk);
        chk("mdu_we_n2", 64'(writeEnable), 64'd1);
        chk("mdu_pend_clr", 64'(pending[7]), 64'd0);
        chk("mdu_cnt0", 64'(fifo_count), 64'd0);
        tick();

        // Full FIFO with ALU held valid: hand-derived write order
        expect_wr(5'd20, 32'hA000_0000);
        expect_wr(5'd21, 32'hA000_0001);
        expect_wr(5'd22, 32'hA000_0002);
        expect_wr(5'd23, 32'hA000_0003);
        expect_wr(5'd1,  32'hB000_0001);
        expect_wr(5'd24, 32'hA000_0004);
        expect_wr(5'd25, 32'hA000_0005);
        expect_wr(5'd26, 32'hA000_0006);
        expect_wr(5'd2,  32'hB000_0002);
        expect_wr(5'd27, 32'hA000_0007);
        expect_wr(5'd3,  32'hB000_0003);
        expect_wr(5'd4,  32'hB000_0004);
        ai = 0;
        for (int c = 0; c < 10; c++) begin
            alu_valid = 1'b1;
            alu_reg   = 5'(20 + ai);
            alu_data  = 32'hA000_0000 + 32'(ai);
            mdu_valid = (c < 4);
            mdu_reg   = 5'(c + 1);
            mdu_data  = 32'hB000_0000 + 32'(c + 1);
            @(negedge clk);
            chk("full_alu_rdy", 64'(alu_ready), 64'(ar[c]));
            chk("full_mdu_rdy", 64'(mdu_ready), 64'(mr[c]));
            chk("full_cnt", 64'(fifo_count), 64'(cn[c]));
            if (c == 4) chk("full_pend", 64'(pending), 64'h1E);
            if (ar[c]) ai++;
            tick();
        end
        alu_valid = 1'b0;
        mdu_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("full_drained", 64'(fifo_count), 64'd0);
        tick();
        tick();

        // WAW hazard on reg 9
        mdu_send(5'd9, 32'h0000_0099);
        alu_valid = 1'b1;
        alu_reg   = 5'd9;
        alu_data  = 32'h0000_00A9;
        @(negedge clk);
        chk("waw_block", 64'(alu_ready), 64'd0);
        chk("waw_pend", 64'(pending[9]), 64'd1);
        tick();
        @(negedge clk);
        chk("waw_release", 64'(alu_ready), 64'd1);
        chk("waw_mdu_reg", 64'(writeReg), 64'd9);
        expect_wr(5'd9, 32'h0000_00A9);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("waw_final", 64'(writeData), 64'hA9);
        tick();

        // Register 0 on both sources
        alu_valid = 1'b1;
        alu_reg   = 5'd0;
        alu_data  = 32'hFFFF_FFFF;
        mdu_valid = 1'b1;
        mdu_reg   = 5'd0;
        mdu_data  = 32'hEEEE_EEEE;
        @(negedge clk);
        chk("r0_alu_rdy", 64'(alu_ready), 64'd1);
        chk("r0_mdu_rdy", 64'(mdu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        mdu_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("r0_we", 64'(writeEnable), 64'd0);
            chk("r0_cnt", 64'(fifo_count), 64'd0);
            chk("r0_pend", 64'(pending), 64'd0);
            tick();
        end

        // Reset mid-drain discards the queued entry
        mdu_send(5'd11, 32'h0000_00C1);
        mdu_send(5'd12, 32'h0000_00C2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_we", 64'(writeEnable), 64'd0);
        chk("mid_rst_reg", 64'(writeReg), 64'd0);
        chk("mid_rst_data", 64'(writeData), 64'd0);
        chk("mid_rst_cnt", 64'(fifo_count), 64'd0);
        chk("mid_rst_pend", 64'(pending), 64'd0);
        repeat (2) tick();
        @(negedge clk);
        chk("mid_rst_hold", 64'(writeEnable), 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("post_rst_we", 64'(writeEnable), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
